// File: rtl/clk_div_prog_pkg.sv
// Shared clock-utility definitions: divisor limits, reset default and the
// divider state encoding reused by the clock blocks.
package clk_div_prog_pkg;

  localparam int DIV_MIN     = 2;
  localparam int DIV_DEFAULT = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable clock divider: N-cycle periods with a round-up high phase,
// divisor changes deferred to period boundaries so no runt pulse is produced.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(DEFAULT_DIV);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] high_len_d;
  logic             boundary;

  assign div_clamped = (div_val < DIV_MIN_W) ? DIV_MIN_W : div_val;
  assign boundary    = (state_q == RUN) && (cnt_q == (div_act_q - CNT_W'(1)));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= DIV_RST_W;
      div_pend_q <= DIV_RST_W;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

  // Outputs are computed from the next counter/divisor so they land in flops
  // aligned with the cycle they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (div_load) div_act_d = div_clamped;
        if (en)       state_d   = RUN;
      end
      RUN: begin
        if (div_load) begin
          div_pend_d = div_clamped;
          pend_d     = 1'b1;
        end
        if (boundary) begin
          cnt_d = '0;
          // A load landing on the boundary stays pending for the next one.
          if (pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = div_load;
          end
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    high_len_d = div_act_d - (div_act_d >> 1);
    running_d  = (state_d == RUN);
    clk_out_d  = running_d && (cnt_d < high_len_d);
    tick_d     = running_d && (cnt_d == '0);
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = running_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed period measurements plus a
// randomized run against a waveform-queue reference model.
module tb_clk_div_prog;

  localparam int CntW   = 16;
  localparam int DefDiv = 256;

  logic            clk_in = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            div_load = 1'b0;
  logic [CntW-1:0] div_val = '0;
  logic            clk_out, tick, running, pend;

  int checks = 0;
  int failures = 0;

  // Reference model: each started period is expanded into its full
  // {clk_out, tick} waveform; a period ends when its queue runs dry.
  bit       mRun;
  bit       mPend;
  int       mN;
  int       mPendN;
  bit [1:0] waveQ[$];
  bit       expClk, expTick;

  // Period measurements taken from the DUT outputs.
  int lenQ[$];
  int highQ[$];
  int curLen = 0;
  int curHigh = 0;

  clk_div_prog #(.CNT_W(CntW), .DEFAULT_DIV(DefDiv)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int clampDiv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void modelReset();
    waveQ.delete();
    mRun = 1'b0;
    mPend = 1'b0;
    mN = DefDiv;
    mPendN = DefDiv;
    expClk = 1'b0;
    expTick = 1'b0;
  endfunction

  function automatic void startPeriod(input int n);
    for (int k = 0; k < n; k++)
      waveQ.push_back({(k < n - n / 2) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
  endfunction

  function automatic void modelEdge();
    bit atEnd;
    atEnd = mRun && (waveQ.size() == 0);
    if (!mRun) begin
      if (div_load) mN = clampDiv(int'(div_val));
      if (en) begin
        startPeriod(mN);
        mRun = 1'b1;
      end
    end else if (!atEnd) begin
      if (div_load) begin
        mPendN = clampDiv(int'(div_val));
        mPend = 1'b1;
      end
    end else begin
      if (mPend) begin
        mN = mPendN;
        mPend = 1'b0;
      end
      if (div_load) begin
        mPendN = clampDiv(int'(div_val));
        mPend = 1'b1;
      end
      if (en) startPeriod(mN);
      else    mRun = 1'b0;
    end
    if (mRun) {expClk, expTick} = waveQ.pop_front();
    else      {expClk, expTick} = 2'b00;
  endfunction

  function automatic void clearMeasure();
    lenQ.delete();
    highQ.delete();
  endfunction

  // One clk_in cycle: inputs are already driven, the model advances on the
  // same edge, and outputs are compared 1 time unit later.
  task automatic applyStimulus(input string tag);
    @(posedge clk_in);
    if (!rst_n) modelReset();
    else        modelEdge();
    #1;
    checkOutput({tag, ".clk_out"}, int'(clk_out), int'(expClk));
    checkOutput({tag, ".tick"},    int'(tick),    int'(expTick));
    checkOutput({tag, ".running"}, int'(running), int'(mRun));
    checkOutput({tag, ".pend"},    int'(pend),    int'(mPend));
    if (tick) begin
      if (curLen > 0) begin
        lenQ.push_back(curLen);
        highQ.push_back(curHigh);
      end
      curLen = 0;
      curHigh = 0;
    end
    if (running) begin
      curLen++;
      curHigh += int'(clk_out);
    end else if (curLen > 0) begin
      lenQ.push_back(curLen);
      highQ.push_back(curHigh);
      curLen = 0;
      curHigh = 0;
    end
  endtask

  task automatic runCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag);
  endtask

  task automatic waitIdle(input string tag);
    en = 1'b0;
    div_load = 1'b0;
    for (int i = 0; i < 600 && running; i++) applyStimulus(tag);
    checkOutput({tag, ".idle"}, int'(running), 0);
  endtask

  task automatic loadIdle(input string tag, input int v);
    div_val = CntW'(v);
    div_load = 1'b1;
    applyStimulus(tag);
    div_load = 1'b0;
  endtask

  task automatic checkPeriod(input string tag, input int idx, input int expLen, input int expHigh);
    checkOutput({tag, ".count"}, (lenQ.size() > idx) ? 1 : 0, 1);
    if (lenQ.size() > idx) begin
      checkOutput({tag, ".len"},  lenQ[idx],  expLen);
      checkOutput({tag, ".high"}, highQ[idx], expHigh);
    end
  endtask

  initial begin
    modelReset();

    // Reset state and default divide-by-256 run straight out of reset.
    #2;
    checkOutput("rst.clk_out", int'(clk_out), 0);
    checkOutput("rst.tick",    int'(tick),    0);
    checkOutput("rst.running", int'(running), 0);
    checkOutput("rst.pend",    int'(pend),    0);
    runCycles("rst", 2);
    en = 1'b1;
    rst_n = 1'b1;
    clearMeasure();
    applyStimulus("def.first");
    checkOutput("def.first_tick", int'(tick), 1);
    runCycles("def", 520);
    checkPeriod("def.p0", 0, 256, 128);
    checkPeriod("def.p1", 1, 256, 128);

    // Odd divisor loaded while idle.
    waitIdle("n5.wait");
    loadIdle("n5.load", 5);
    clearMeasure();
    en = 1'b1;
    runCycles("n5", 16);
    checkPeriod("n5.p0", 0, 5, 3);
    checkPeriod("n5.p1", 1, 5, 3);

    // Mid-period load takes effect only at the next boundary.
    waitIdle("n10.wait");
    loadIdle("n10.load", 10);
    clearMeasure();
    en = 1'b1;
    runCycles("n10.lead", 4);
    div_val = CntW'(4);
    div_load = 1'b1;
    applyStimulus("n10.ld4");
    div_load = 1'b0;
    checkOutput("n10.pend_set", int'(pend), 1);
    runCycles("n10", 20);
    checkPeriod("n10.p0", 0, 10, 5);
    checkPeriod("n10.p1", 1, 4, 2);
    checkPeriod("n10.p2", 2, 4, 2);
    checkOutput("n10.pend_clr", int'(pend), 0);

    // Divisors 0 and 1 clamp to 2; the second load arrives together with en.
    waitIdle("n0.wait");
    loadIdle("n0.load", 0);
    clearMeasure();
    en = 1'b1;
    runCycles("n0", 7);
    checkPeriod("n0.p0", 0, 2, 1);
    waitIdle("n1.wait");
    clearMeasure();
    div_val = CntW'(1);
    div_load = 1'b1;
    en = 1'b1;
    applyStimulus("n1.load");
    div_load = 1'b0;
    runCycles("n1", 6);
    checkPeriod("n1.p0", 0, 2, 1);

    // en dropped mid-period: the period completes, then restart ticks at once.
    waitIdle("n8.wait");
    loadIdle("n8.load", 8);
    clearMeasure();
    en = 1'b1;
    runCycles("n8.lead", 3);
    en = 1'b0;
    for (int i = 0; i < 20 && running; i++) applyStimulus("n8.drain");
    checkPeriod("n8.p0", 0, 8, 4);
    checkOutput("n8.clk_low", int'(clk_out), 0);
    checkOutput("n8.stopped", int'(running), 0);
    en = 1'b1;
    applyStimulus("n8.restart");
    checkOutput("n8.retick", int'(tick), 1);

    // Asynchronous reset with a pending divisor.
    waitIdle("ar.wait");
    loadIdle("ar.load", 20);
    en = 1'b1;
    runCycles("ar.lead", 5);
    div_val = CntW'(7);
    div_load = 1'b1;
    applyStimulus("ar.ld7");
    div_load = 1'b0;
    checkOutput("ar.pend_set", int'(pend), 1);
    applyStimulus("ar.mid");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar.clk_out", int'(clk_out), 0);
    checkOutput("ar.tick",    int'(tick),    0);
    checkOutput("ar.running", int'(running), 0);
    checkOutput("ar.pend",    int'(pend),    0);
    modelReset();
    applyStimulus("ar.hold");
    rst_n = 1'b1;
    clearMeasure();
    runCycles("ar.post", 260);
    checkPeriod("ar.p0", 0, 256, 128);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      div_load = ($urandom_range(0, 15) == 0);
      div_val = CntW'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 999) != 0);
      applyStimulus("rnd");
    end
    rst_n = 1'b1;
    div_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
